// File: rtl/util_pkg.sv
// Shared front-end types: the fetched packet record, the fetch group width,
// and the fetch queue depth.
package util_pkg;

   localparam int INSTR_COUNT = 2;
   localparam int FQ_DEPTH    = 8;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
      logic        taken_branch;
   } fetched_packet;

   localparam int FETCHED_PACKET_BITS = $bits(fetched_packet);

endpackage

// File: rtl/fetch_queue_compact.sv
// Packs the valid slots of a fetch group towards slot 0, keeping program
// order, and reports how many packets the group carries.
module fetch_queue_compact
   import util_pkg::*;
#(
   parameter int INSTR_COUNT = util_pkg::INSTR_COUNT,
   parameter int PACKET_SIZE = util_pkg::FETCHED_PACKET_BITS,
   parameter int CNT_W       = 4
) (
   input  logic [INSTR_COUNT-1:0]             valid_i,
   input  logic [INSTR_COUNT*PACKET_SIZE-1:0] packet_i,
   output logic [INSTR_COUNT-1:0]             valid_o,
   output logic [INSTR_COUNT*PACKET_SIZE-1:0] packet_o,
   output logic [CNT_W-1:0]                   count_o
);

   logic [CNT_W-1:0] slot;

   always_comb begin
      packet_o = '0;
      slot     = '0;
      for (int k = 0; k < INSTR_COUNT; k++) begin
         if (valid_i[k]) begin
            packet_o[slot*PACKET_SIZE +: PACKET_SIZE] = packet_i[k*PACKET_SIZE +: PACKET_SIZE];
            slot = slot + CNT_W'(1);
         end
      end
      count_o = slot;
   end

   // Compacted valids are thermometer coded by construction.
   always_comb begin
      valid_o = '0;
      for (int k = 0; k < INSTR_COUNT; k++) begin
         valid_o[k] = (count_o > CNT_W'(k));
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// IF->ID decoupling FIFO, INSTR_COUNT packets per cycle each side.
// Optional same-cycle empty-queue bypass: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue
   import util_pkg::*;
#(
   parameter int DEPTH       = util_pkg::FQ_DEPTH,
   parameter int PACKET_SIZE = util_pkg::FETCHED_PACKET_BITS,
   parameter int INSTR_COUNT = util_pkg::INSTR_COUNT
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               flush_i,
   input  logic [INSTR_COUNT-1:0]             valid_i,
   input  logic [INSTR_COUNT*PACKET_SIZE-1:0] packet_i,
   output logic                               ready_o,
   output logic [INSTR_COUNT-1:0]             valid_o,
   output logic [INSTR_COUNT*PACKET_SIZE-1:0] packet_o,
   input  logic                               ready_i,
   output logic [$clog2(DEPTH):0]             count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PACKET_SIZE-1:0]             mem [DEPTH];
   logic [PTR_W-1:0]                   head;
   logic [PTR_W-1:0]                   tail;
   logic [CNT_W-1:0]                   count;

   logic [INSTR_COUNT-1:0]             comp_valid;
   logic [INSTR_COUNT*PACKET_SIZE-1:0] comp_packet;
   logic [CNT_W-1:0]                   comp_count;

   logic [INSTR_COUNT-1:0]             st_valid;
   logic [INSTR_COUNT*PACKET_SIZE-1:0] st_packet;
   logic                               push_ok;
   logic [CNT_W-1:0]                   push_n;
   logic [CNT_W-1:0]                   pop_n;

   fetch_queue_compact #(
      .INSTR_COUNT (INSTR_COUNT),
      .PACKET_SIZE (PACKET_SIZE),
      .CNT_W       (CNT_W)
   ) u_compact (
      .valid_i  (valid_i),
      .packet_i (packet_i),
      .valid_o  (comp_valid),
      .packet_o (comp_packet),
      .count_o  (comp_count)
   );

   // Only registered occupancy feeds ready_o, keeping IF timing independent of ID.
   assign ready_o = (count <= CNT_W'(DEPTH - INSTR_COUNT));
   assign count_o = count;
   assign push_ok = ready_o && (|comp_valid);

   always_comb begin
      st_valid  = '0;
      st_packet = '0;
      for (int k = 0; k < INSTR_COUNT; k++) begin
         st_valid[k]                           = (count > CNT_W'(k));
         st_packet[k*PACKET_SIZE +: PACKET_SIZE] = mem[head + PTR_W'(k)];
      end
   end

   always_comb begin
      pop_n = '0;
      if (ready_i) begin
         pop_n = (count > CNT_W'(INSTR_COUNT)) ? CNT_W'(INSTR_COUNT) : count;
      end
   end

`ifdef FETCH_QUEUE_BYPASS_EN
   logic bypass;

   // An empty queue forwards the incoming group; ID taking it means it is never stored.
   always_comb begin
      bypass   = (count == '0) && !flush_i;
      push_n   = (push_ok && !(bypass && ready_i)) ? comp_count : '0;
      valid_o  = bypass ? comp_valid  : st_valid;
      packet_o = bypass ? comp_packet : st_packet;
   end
`else
   always_comb begin
      push_n   = push_ok ? comp_count : '0;
      valid_o  = st_valid;
      packet_o = st_packet;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + pop_n[PTR_W-1:0];
         tail  <= tail + push_n[PTR_W-1:0];
         count <= count + push_n - pop_n;
      end
   end

   // Storage is not reset: entries beyond count are never observed as valid.
   always_ff @(posedge clk) begin
      if (!flush_i) begin
         for (int k = 0; k < INSTR_COUNT; k++) begin
            if (CNT_W'(k) < push_n) begin
               mem[tail + PTR_W'(k)] <= comp_packet[k*PACKET_SIZE +: PACKET_SIZE];
            end
         end
      end
   end

   occupancy_bound: assert property (@(posedge clk) disable iff (!rst_n)
      count <= CNT_W'(DEPTH));

   valid_thermometer: assert property (@(posedge clk) disable iff (!rst_n)
      ((valid_o + INSTR_COUNT'(1)) & valid_o) == '0);

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, corner sequences,
// and a randomized run against a queue-based reference model.
module tb_fetch_queue;
   import util_pkg::*;

   localparam int DEPTH = 8;
   localparam int PS    = 65;
   localparam int IC    = 2;
   localparam int CW    = 4;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               flush_i = 1'b0;
   logic [IC-1:0]      valid_i = '0;
   logic [IC*PS-1:0]   packet_i = '0;
   logic               ready_o;
   logic [IC-1:0]      valid_o;
   logic [IC*PS-1:0]   packet_o;
   logic               ready_i = 1'b0;
   logic [CW-1:0]      count_o;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_queue #(.DEPTH(DEPTH), .PACKET_SIZE(PS), .INSTR_COUNT(IC)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush_i  (flush_i),
      .valid_i  (valid_i),
      .packet_i (packet_i),
      .ready_o  (ready_o),
      .valid_o  (valid_o),
      .packet_o (packet_o),
      .ready_i  (ready_i),
      .count_o  (count_o)
   );

   always #5 clk = ~clk;

   function automatic logic [PS-1:0] mk(input logic [31:0] pc);
      fetched_packet p;
      p.pc           = pc;
      p.data         = pc ^ 32'hA5A5_0F0F;
      p.taken_branch = pc[3];
      return p;
   endfunction

   function automatic logic [31:0] out_pc(input int k);
      fetched_packet p;
      p = packet_o[k*PS +: PS];
      return p.pc;
   endfunction

   task automatic chk(input string nm, input logic [PS-1:0] act, input logic [PS-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [IC-1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                        input logic rdy, input logic fl);
      valid_i  = v;
      packet_i = {mk(pc1), mk(pc0)};
      ready_i  = rdy;
      flush_i  = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [1:0]  v;
      logic [31:0] pc0;
      logic [31:0] pc1;
      logic        rdy;
      logic        fl;
      logic [1:0]  ev;
      logic [31:0] epc0;
      logic [31:0] epc1;
      logic [3:0]  ecnt;
      logic        erdy;
   } vec_t;

   vec_t tbl[20];

   typedef logic [PS-1:0] pkt_t;
   pkt_t q[$];
   pkt_t cin[$];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{2'b11, 32'h100,  32'h104,  1'b0, 1'b0, 2'b11, 32'h100, 32'h104, 4'd2, 1'b1};
      tbl[1]  = '{2'b00, 32'h0,    32'h0,    1'b1, 1'b0, 2'b00, 32'h0,   32'h0,   4'd0, 1'b1};
      tbl[2]  = '{2'b10, 32'hdead, 32'h204,  1'b0, 1'b0, 2'b01, 32'h204, 32'h0,   4'd1, 1'b1};
      tbl[3]  = '{2'b11, 32'h300,  32'h304,  1'b1, 1'b0, 2'b11, 32'h300, 32'h304, 4'd2, 1'b1};
      tbl[4]  = '{2'b01, 32'h400,  32'h0,    1'b1, 1'b0, 2'b01, 32'h400, 32'h0,   4'd1, 1'b1};
      tbl[5]  = '{2'b11, 32'h500,  32'h504,  1'b0, 1'b0, 2'b11, 32'h400, 32'h500, 4'd3, 1'b1};
      tbl[6]  = '{2'b11, 32'h600,  32'h604,  1'b0, 1'b0, 2'b11, 32'h400, 32'h500, 4'd5, 1'b1};
      tbl[7]  = '{2'b11, 32'h700,  32'h704,  1'b1, 1'b1, 2'b00, 32'h0,   32'h0,   4'd0, 1'b1};
      tbl[8]  = '{2'b11, 32'h800,  32'h804,  1'b0, 1'b0, 2'b11, 32'h800, 32'h804, 4'd2, 1'b1};
      tbl[9]  = '{2'b11, 32'h900,  32'h904,  1'b0, 1'b0, 2'b11, 32'h800, 32'h804, 4'd4, 1'b1};
      tbl[10] = '{2'b11, 32'ha00,  32'ha04,  1'b0, 1'b0, 2'b11, 32'h800, 32'h804, 4'd6, 1'b1};
      tbl[11] = '{2'b11, 32'hb00,  32'hb04,  1'b0, 1'b0, 2'b11, 32'h800, 32'h804, 4'd8, 1'b0};
      tbl[12] = '{2'b11, 32'hc00,  32'hc04,  1'b0, 1'b0, 2'b11, 32'h800, 32'h804, 4'd8, 1'b0};
      tbl[13] = '{2'b00, 32'h0,    32'h0,    1'b1, 1'b0, 2'b11, 32'h900, 32'h904, 4'd6, 1'b1};
      tbl[14] = '{2'b11, 32'hd00,  32'hd04,  1'b0, 1'b0, 2'b11, 32'h900, 32'h904, 4'd8, 1'b0};
      tbl[15] = '{2'b00, 32'h0,    32'h0,    1'b1, 1'b0, 2'b11, 32'ha00, 32'ha04, 4'd6, 1'b1};
      tbl[16] = '{2'b01, 32'he00,  32'h0,    1'b0, 1'b0, 2'b11, 32'ha00, 32'ha04, 4'd7, 1'b0};
      tbl[17] = '{2'b01, 32'hf00,  32'h0,    1'b0, 1'b0, 2'b11, 32'ha00, 32'ha04, 4'd7, 1'b0};
      tbl[18] = '{2'b00, 32'h0,    32'h0,    1'b1, 1'b0, 2'b11, 32'hb00, 32'hb04, 4'd5, 1'b1};
      tbl[19] = '{2'b11, 32'h1000, 32'h1004, 1'b0, 1'b1, 2'b00, 32'h0,   32'h0,   4'd0, 1'b1};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid", PS'(valid_o), PS'(2'b00));
      chk("reset_count", PS'(count_o), PS'(4'd0));
      chk("reset_ready", PS'(ready_o), PS'(1'b1));
      @(negedge clk);
      rst_n = 1'b1;
      #4;

      // Directed vector table
      for (int i = 0; i < 20; i++) begin
         drive(tbl[i].v, tbl[i].pc0, tbl[i].pc1, tbl[i].rdy, tbl[i].fl);
         tick();
         chk($sformatf("tbl%0d_valid", i), PS'(valid_o), PS'(tbl[i].ev));
         chk($sformatf("tbl%0d_count", i), PS'(count_o), PS'(tbl[i].ecnt));
         chk($sformatf("tbl%0d_ready", i), PS'(ready_o), PS'(tbl[i].erdy));
         if (tbl[i].ev[0]) chk($sformatf("tbl%0d_pc0", i), PS'(out_pc(0)), PS'(tbl[i].epc0));
         if (tbl[i].ev[1]) chk($sformatf("tbl%0d_pc1", i), PS'(out_pc(1)), PS'(tbl[i].epc1));
      end

      // Partial group into an empty queue while ID is ready
      drive(2'b10, 32'hdead, 32'h204, 1'b1, 1'b0);
      #1;
`ifdef FETCH_QUEUE_BYPASS_EN
      chk("part_same_valid", PS'(valid_o), PS'(2'b01));
      chk("part_same_pc0", PS'(out_pc(0)), PS'(32'h204));
`else
      chk("part_same_valid", PS'(valid_o), PS'(2'b00));
`endif
      tick();
      drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
      #1;
`ifdef FETCH_QUEUE_BYPASS_EN
      chk("part_next_valid", PS'(valid_o), PS'(2'b00));
      chk("part_next_count", PS'(count_o), PS'(4'd0));
`else
      chk("part_next_valid", PS'(valid_o), PS'(2'b01));
      chk("part_next_pc0", PS'(out_pc(0)), PS'(32'h204));
      chk("part_next_count", PS'(count_o), PS'(4'd1));
`endif
      tick();
      chk("part_drained_count", PS'(count_o), PS'(4'd0));
      chk("part_drained_valid", PS'(valid_o), PS'(2'b00));

      // Full group into an empty queue while ID is ready
      drive(2'b11, 32'h120, 32'h124, 1'b1, 1'b0);
      #1;
      chk("byp_same_count", PS'(count_o), PS'(4'd0));
`ifdef FETCH_QUEUE_BYPASS_EN
      chk("byp_same_valid", PS'(valid_o), PS'(2'b11));
      chk("byp_same_pc0", PS'(out_pc(0)), PS'(32'h120));
      chk("byp_same_pc1", PS'(out_pc(1)), PS'(32'h124));
`else
      chk("byp_same_valid", PS'(valid_o), PS'(2'b00));
`endif
      tick();
      drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
      #1;
`ifdef FETCH_QUEUE_BYPASS_EN
      chk("byp_next_count", PS'(count_o), PS'(4'd0));
`else
      chk("byp_next_count", PS'(count_o), PS'(4'd2));
      chk("byp_next_pc0", PS'(out_pc(0)), PS'(32'h120));
`endif
      drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
      chk("byp_drained_count", PS'(count_o), PS'(4'd0));

      // Asynchronous reset in the middle of a cycle
      drive(2'b11, 32'h140, 32'h144, 1'b0, 1'b0);
      tick();
      tick();
      drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("pre_rst_count", PS'(count_o), PS'(4'd4));
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_count", PS'(count_o), PS'(4'd0));
      chk("async_rst_valid", PS'(valid_o), PS'(2'b00));
      chk("async_rst_ready", PS'(ready_o), PS'(1'b1));
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("post_rst_count", PS'(count_o), PS'(4'd0));

      // Randomized traffic against the queue model
      begin
         logic [31:0] next_pc;
         next_pc = 32'h1_0000;
         for (int cyc = 0; cyc < 1200; cyc++) begin
            logic [IC-1:0] v;
            logic          rdy, fl, bypass, accept;
            logic [31:0]   pc0, pc1;
            logic [IC-1:0] ev;
            pkt_t          exp_slot[IC];
            int            sz, npop;

            v   = ($urandom_range(0, 99) < 80) ? 2'b11 : IC'($urandom_range(0, 3));
            rdy = ($urandom_range(0, 99) >= 30);
            fl  = ($urandom_range(0, 199) == 0);
            pc0 = next_pc;
            pc1 = next_pc + 32'd4;
            next_pc = next_pc + 32'd8;
            drive(v, pc0, pc1, rdy, fl);
            #1;

            cin.delete();
            if (v[0]) cin.push_back(mk(pc0));
            if (v[1]) cin.push_back(mk(pc1));
            sz = q.size();
`ifdef FETCH_QUEUE_BYPASS_EN
            bypass = (sz == 0) && !fl;
`else
            bypass = 1'b0;
`endif
            ev = '0;
            for (int k = 0; k < IC; k++) begin
               exp_slot[k] = '0;
               if (bypass) begin
                  if (k < cin.size()) begin
                     ev[k] = 1'b1;
                     exp_slot[k] = cin[k];
                  end
               end else if (k < sz) begin
                  ev[k] = 1'b1;
                  exp_slot[k] = q[k];
               end
            end
            chk("rnd_valid", PS'(valid_o), PS'(ev));
            chk("rnd_count", PS'(count_o), PS'(sz));
            chk("rnd_ready", PS'(ready_o), PS'(DEPTH - sz >= IC));
            for (int k = 0; k < IC; k++) begin
               if (ev[k]) chk($sformatf("rnd_slot%0d", k), packet_o[k*PS +: PS], exp_slot[k]);
            end

            if (fl) begin
               q.delete();
            end else begin
               accept = (DEPTH - sz >= IC) && (v != '0);
               npop = (rdy && !bypass) ? ((sz < IC) ? sz : IC) : 0;
               for (int k = 0; k < npop; k++) void'(q.pop_front());
               if (accept && !(bypass && rdy)) begin
                  foreach (cin[k]) q.push_back(cin[k]);
               end
            end
            @(posedge clk);
            #1;
         end
      end

      drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
      repeat (DEPTH) tick();
      chk("final_drain_count", PS'(count_o), PS'(4'd0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling FIFO between the fetch (IF) stage and decode (ID).
- Accepts up to INSTR_COUNT fetched packets per cycle from IF and holds them in program order. Each packet is {pc[31:0], data[31:0], taken_branch}, PACKET_SIZE bits.
- Presents up to INSTR_COUNT oldest packets per cycle to ID.
- Absorbs ID stalls and icache partial accesses. Discards all contents on a pipeline flush/restart.

Parameters:
- DEPTH, 8: queue entries; power of 2, >= 2*INSTR_COUNT.
- PACKET_SIZE, 65: bits per fetched packet.
- INSTR_COUNT, 2: packets per cycle on each side.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush_i  in  1  discard all contents (restart/flush from backend).
- valid_i  in  INSTR_COUNT  per-slot valid of incoming fetch group from IF.
- packet_i  in  INSTR_COUNT*PACKET_SIZE  incoming packets; slot 0 is the oldest.
- ready_o  out  1  to IF: queue can accept a full group this cycle.
- valid_o  out  INSTR_COUNT  per-slot valid to ID; thermometer coded (valid_o[1] implies valid_o[0]).
- packet_o  out  INSTR_COUNT*PACKET_SIZE  oldest packets; slot 0 is the oldest.
- ready_i  in  1  from ID: consume every slot with valid_o set.
- count_o  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, rst_n=0): head pointer = 0, tail pointer = 0, count = 0, valid_o = 0, count_o = 0, ready_o = 1. packet_o is don't-care but driven from storage, so no X on the valid bits.
- Storage: DEPTH x PACKET_SIZE array.
  - head/tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
  - count is a separate register; full = (count == DEPTH).
- ready_o = (DEPTH - count >= INSTR_COUNT). It is driven from registered count only, with no combinational path from ready_i or flush_i.
- Push: accepted when ready_o && |valid_i.
  - Valid slots are compacted in slot order and written to tail, tail+1, ...
  - Example: valid_i = 2'b10 writes only slot 1, at tail.
  - tail += popcount(valid_i).
  - valid_i asserted while ready_o = 0 is ignored. IF must hold its group and retry.
- Output: valid_o[k] = (count > k); packet_o slot k = mem[head+k] (modulo DEPTH).
- Pop: when ready_i = 1, head += popcount(valid_o). ready_i with valid_o = 0 is a no-op.
- Same cycle push and pop: count_next = count + pushed - popped. Both pointers update independently. Pop sees only entries present at the start of the cycle, so latency IF to ID is 1 cycle minimum.
- Flush (flush_i = 1): next cycle has head = tail = 0 and count = 0. Any push or pop in the same cycle is discarded. valid_o drops to 0 the cycle after flush. IF may push on the cycle after flush (ready_o = 1 then).
- Wrap-around: a group straddling mem[DEPTH-1] and mem[0] is written and read correctly.
- Almost full: count = DEPTH-1 gives ready_o = 0, even when the incoming group has a single valid slot.
- Reset mid-operation: immediate clear to the reset values above. No partial writes survive.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When count == 0 and flush_i = 0, compacted valid_i/packet_i drive valid_o/packet_o combinationally in the same cycle.
  - If ready_i = 1, the bypassed packets are consumed and not written.
  - If ready_i = 0, they are written normally.
  - Latency becomes 0 cycles when empty.
- Undefined: no bypass; latency is always >= 1 cycle and outputs come only from registers/storage.

Decomposition:
- Shared package (util_pkg): fetched_packet struct, INSTR_COUNT, and a new FQ_DEPTH constant. The package already holds the fetched_packet struct and INSTR_COUNT; FQ_DEPTH is the only addition.
- One sub-module: fetch_queue_compact. It is combinational; it takes valid_i/packet_i and returns compacted packets plus a push count. It is also reused by the bypass path.

Test Plan:
- Reset then push valid_i=2'b11 (pc 0x100, 0x104) with ready_i=0 -> next cycle valid_o=2'b11, packet_o slot0 pc=0x100, count_o=2.
- Partial group valid_i=2'b10 (pc 0x204) into an empty queue, ready_i=1 -> next cycle valid_o=2'b01, slot0 pc=0x204; following cycle count_o=0.
- Fill with ready_i=0: after 4 full groups count_o=8 and ready_o=0. Push attempts are ignored. Assert ready_i for 1 cycle -> count_o=6, ready_o=1.
- Wrap: steady stream of 2-packet pushes with ready_i toggling at 30% stall for 1000 cycles -> output PC order equals input PC order and no packet is lost or duplicated.
- Flush with count=5 while valid_i=2'b11 -> next cycle count_o=0 and valid_o=0. The same-cycle group does not appear.
- Bypass build, empty queue, valid_i=2'b11, ready_i=1 -> valid_o=2'b11 in the same cycle and count_o stays 0. Non-bypass build -> valid_o=0 that cycle.
